boarding_gate_controller: RTL and testbench
===========================================

BOARDING_GATE_CONTROLLER -- requirements
Module: boarding_gate_controller

Interface
REQ-001 The block SHALL have parameter MIN_PAX, default 15, giving the minimum passenger count accepted for a departure request.
REQ-002 The block SHALL have parameter CAPACITY, default 62, giving the maximum passenger count (range 1..63).
REQ-003 The block SHALL have parameter CLR_TIMEOUT, default 255, giving the WAIT_CLR cycles allowed before returning to boarding.
REQ-004 The block SHALL have parameter DEPART_CYC, default 8, giving the cycles spent in DEPART.
REQ-005 The block SHALL have port clk, input, 1 bit, the single system clock; all logic is rising-edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit, the reset; asynchronous, active-low.
REQ-007 The block SHALL have port pax_in, input, 1 bit, a one-cycle pulse when a passenger boards.
REQ-008 The block SHALL have port pax_out, input, 1 bit, a one-cycle pulse when a passenger leaves.
REQ-009 The block SHALL have port close_req, input, 1 bit, a one-cycle pulse requesting gate close.
REQ-010 The block SHALL have port clearance, input, 1 bit, a level from the airfield controller; 1 means runway free.
REQ-011 The block SHALL have port weather, input, 1 bit, a level; 1 means flyable.
REQ-012 The block SHALL have port passengers, output, 6 bits, the registered passenger count sent to the airfield controller.
REQ-013 The block SHALL have port depart_req, output, 1 bit, high for every cycle the FSM is in WAIT_CLR.
REQ-014 The block SHALL have port departed, output, 1 bit, a one-cycle pulse on the last DEPART cycle.
REQ-015 The block SHALL have port reject, output, 1 bit, a one-cycle pulse when a request or event is refused.
REQ-016 The block SHALL have port full, output, 1 bit, high when passengers == CAPACITY.
REQ-017 The block SHALL have port state, output, 2 bits, the FSM encoding: IDLE=00, BOARDING=01, WAIT_CLR=10, DEPART=11.

Function
REQ-018 All outputs SHALL be registered, with one-cycle latency from input to output.
REQ-019 In IDLE, pax_in SHALL set passengers=1 and go to BOARDING; pax_out and close_req SHALL produce reject.
REQ-020 In BOARDING, pax_in alone SHALL increment passengers; at CAPACITY the count SHALL hold and reject SHALL pulse.
REQ-021 In BOARDING, pax_out alone SHALL decrement passengers; reaching 0 SHALL go to IDLE the same cycle.
REQ-022 In BOARDING, pax_in and pax_out in the same cycle SHALL leave passengers unchanged, with no reject.
REQ-023 In BOARDING, close_req with passengers >= MIN_PAX SHALL go to WAIT_CLR; otherwise the FSM SHALL stay in BOARDING and reject SHALL pulse.
REQ-024 If close_req coincides with pax_in/pax_out, the count update SHALL apply first and the MIN_PAX check SHALL use the updated count.
REQ-025 In WAIT_CLR, pax_in/pax_out SHALL be ignored and reject SHALL pulse; passengers SHALL be frozen.
REQ-026 In WAIT_CLR, clearance==1 and weather==1 sampled in the same cycle SHALL go to DEPART next cycle.
REQ-027 In WAIT_CLR, an 8-bit-or-wider wait counter SHALL count cycles; after CLR_TIMEOUT cycles without a transition, the FSM SHALL return to BOARDING with count retained and reject pulsed.
REQ-028 Clearance and weather both high on the timeout cycle SHALL take priority: go to DEPART, no reject.
REQ-029 DEPART SHALL last exactly DEPART_CYC cycles, ignoring all inputs; departed SHALL pulse on the last cycle; the next state SHALL be IDLE with passengers=0.
REQ-030 The wait and depart counters SHALL clear on every state entry.

Reset
REQ-031 rst_n low SHALL immediately force: state=IDLE, passengers=0, depart_req=0, departed=0, reject=0, full=0, all counters 0.
REQ-032 Reset asserted mid-WAIT_CLR or mid-DEPART SHALL abort with no departed pulse.
REQ-033 After rst_n deasserts, the first state change SHALL occur no earlier than the next rising clk edge.

Verification
REQ-034 The bench SHALL cover: reset, 15 pax_in pulses, close_req -> passengers=6'b001111, depart_req=1 next cycle, state=10.
REQ-035 The bench SHALL cover: 14 pax_in, close_req -> reject pulse, state stays 01, passengers=14.
REQ-036 The bench SHALL cover: 63 pax_in pulses -> passengers=62, full=1, reject on the 63rd; simultaneous pax_in+pax_out -> count unchanged.
REQ-037 The bench SHALL cover: WAIT_CLR with weather=0, clearance=1 for 255 cycles -> state=01, reject pulse, passengers kept.
REQ-038 The bench SHALL cover: WAIT_CLR, clearance=weather=1 -> DEPART for 8 cycles, departed on the 8th, then IDLE, passengers=0.
REQ-039 The bench SHALL cover: rst_n pulled low in DEPART cycle 4 -> all outputs 0 asynchronously, no departed pulse.

Source files
------------

// File: rtl/boarding_gate_controller.sv
// Boarding gate controller: counts passengers, requests departure clearance,
// and sequences the timed departure. All outputs are registered.
module boarding_gate_controller #(
  parameter int MIN_PAX     = 15,
  parameter int CAPACITY    = 62,
  parameter int CLR_TIMEOUT = 255,
  parameter int DEPART_CYC  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pax_in,
  input  logic       pax_out,
  input  logic       close_req,
  input  logic       clearance,
  input  logic       weather,
  output logic [5:0] passengers,
  output logic       depart_req,
  output logic       departed,
  output logic       reject,
  output logic       full,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    BOARDING = 2'b01,
    WAIT_CLR = 2'b10,
    DEPART   = 2'b11
  } state_t;

  localparam int WW = ($clog2(CLR_TIMEOUT) > 8) ? $clog2(CLR_TIMEOUT) : 8;
  localparam int DW = (DEPART_CYC > 1) ? $clog2(DEPART_CYC) : 1;

  localparam logic [5:0]    CAP6  = 6'(CAPACITY);
  localparam logic [5:0]    MIN6  = 6'(MIN_PAX);
  localparam logic [WW-1:0] WMAX  = WW'(CLR_TIMEOUT - 1);
  localparam logic [DW-1:0] DLAST = DW'(DEPART_CYC - 1);

  state_t        cur, nxt;
  logic [5:0]    count_nxt;
  logic [5:0]    updated;
  logic [WW-1:0] wcnt, wcnt_nxt;
  logic [DW-1:0] dcnt, dcnt_nxt;
  logic          reject_nxt;
  logic          departed_nxt;

  // Counters default to zero so that any state change clears them on entry.
  always_comb begin
    nxt          = cur;
    count_nxt    = passengers;
    updated      = passengers;
    reject_nxt   = 1'b0;
    departed_nxt = 1'b0;
    wcnt_nxt     = '0;
    dcnt_nxt     = '0;

    case (cur)
      IDLE: begin
        if (pax_in && !pax_out) begin
          count_nxt = 6'd1;
          nxt       = BOARDING;
        end
        if ((pax_out && !pax_in) || close_req)
          reject_nxt = 1'b1;
      end

      BOARDING: begin
        if (pax_in && !pax_out) begin
          if (passengers == CAP6)
            reject_nxt = 1'b1;
          else
            updated = passengers + 6'd1;
        end else if (pax_out && !pax_in) begin
          updated = passengers - 6'd1;
        end
        count_nxt = updated;
        // The close decision is made on the count after this cycle's update.
        if (updated == 6'd0) begin
          nxt = IDLE;
          if (close_req)
            reject_nxt = 1'b1;
        end else if (close_req) begin
          if (updated >= MIN6)
            nxt = WAIT_CLR;
          else
            reject_nxt = 1'b1;
        end
      end

      WAIT_CLR: begin
        if (pax_in || pax_out)
          reject_nxt = 1'b1;
        if (clearance && weather) begin
          nxt = DEPART;
        end else if (wcnt == WMAX) begin
          nxt        = BOARDING;
          reject_nxt = 1'b1;
        end else begin
          wcnt_nxt = wcnt + 1'b1;
        end
      end

      DEPART: begin
        if (dcnt == DLAST) begin
          nxt       = IDLE;
          count_nxt = 6'd0;
        end else begin
          dcnt_nxt = dcnt + 1'b1;
        end
      end

      default: nxt = IDLE;
    endcase

    departed_nxt = (nxt == DEPART) && (dcnt_nxt == DLAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur        <= IDLE;
      passengers <= 6'd0;
      wcnt       <= '0;
      dcnt       <= '0;
      depart_req <= 1'b0;
      departed   <= 1'b0;
      reject     <= 1'b0;
      full       <= 1'b0;
    end else begin
      cur        <= nxt;
      passengers <= count_nxt;
      wcnt       <= wcnt_nxt;
      dcnt       <= dcnt_nxt;
      depart_req <= (nxt == WAIT_CLR);
      departed   <= departed_nxt;
      reject     <= reject_nxt;
      full       <= (count_nxt == CAP6);
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_boarding_gate_controller.sv
// Self-checking bench for boarding_gate_controller: directed scenarios followed
// by a randomized run, all compared against a rule-level reference model.
module tb_boarding_gate_controller;

  localparam int MIN_PAX     = 15;
  localparam int CAPACITY    = 62;
  localparam int CLR_TIMEOUT = 255;
  localparam int DEPART_CYC  = 8;

  localparam int PH_IDLE  = 0;
  localparam int PH_BOARD = 1;
  localparam int PH_WAIT  = 2;
  localparam int PH_DEP   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pax_in = 1'b0;
  logic       pax_out = 1'b0;
  logic       close_req = 1'b0;
  logic       clearance = 1'b0;
  logic       weather = 1'b0;
  logic [5:0] passengers;
  logic       depart_req;
  logic       departed;
  logic       reject;
  logic       full;
  logic [1:0] state;

  int tests = 0;
  int failed = 0;

  int m_phase = PH_IDLE;
  int m_count = 0;
  int m_wait = 0;
  int m_left = 0;
  bit exp_reject = 1'b0;
  bit exp_departed = 1'b0;

  boarding_gate_controller #(
    .MIN_PAX(MIN_PAX),
    .CAPACITY(CAPACITY),
    .CLR_TIMEOUT(CLR_TIMEOUT),
    .DEPART_CYC(DEPART_CYC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pax_in(pax_in),
    .pax_out(pax_out),
    .close_req(close_req),
    .clearance(clearance),
    .weather(weather),
    .passengers(passengers),
    .depart_req(depart_req),
    .departed(departed),
    .reject(reject),
    .full(full),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_phase = PH_IDLE;
    m_count = 0;
    m_wait = 0;
    m_left = 0;
    exp_reject = 1'b0;
    exp_departed = 1'b0;
  endtask

  // One clock of the gate rules, producing the outputs visible after the edge.
  task automatic modelStep(input bit i, input bit o, input bit c, input bit cl, input bit w);
    exp_reject = 1'b0;
    case (m_phase)
      PH_IDLE: begin
        if (i && !o) begin
          m_count = 1;
          m_phase = PH_BOARD;
        end
        if ((o && !i) || c) exp_reject = 1'b1;
      end
      PH_BOARD: begin
        if (i && !o) begin
          if (m_count == CAPACITY) exp_reject = 1'b1;
          else m_count++;
        end else if (o && !i) begin
          m_count--;
        end
        if (m_count == 0) begin
          m_phase = PH_IDLE;
          if (c) exp_reject = 1'b1;
        end else if (c) begin
          if (m_count >= MIN_PAX) begin
            m_phase = PH_WAIT;
            m_wait = 0;
          end else begin
            exp_reject = 1'b1;
          end
        end
      end
      PH_WAIT: begin
        m_wait++;
        if (i || o) exp_reject = 1'b1;
        if (cl && w) begin
          m_phase = PH_DEP;
          m_left = DEPART_CYC;
        end else if (m_wait >= CLR_TIMEOUT) begin
          m_phase = PH_BOARD;
          exp_reject = 1'b1;
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) begin
          m_phase = PH_IDLE;
          m_count = 0;
        end
      end
    endcase
    exp_departed = (m_phase == PH_DEP) && (m_left == 1);
  endtask

  task automatic checkOutput();
    check1("state", state, 8'(m_phase));
    check1("passengers", passengers, 8'(m_count));
    check1("depart_req", depart_req, 8'(m_phase == PH_WAIT));
    check1("full", full, 8'(m_count == CAPACITY));
    check1("reject", reject, 8'(exp_reject));
    check1("departed", departed, 8'(exp_departed));
  endtask

  task automatic applyStimulus(input bit i, input bit o, input bit c, input bit cl, input bit w);
    pax_in = i;
    pax_out = o;
    close_req = c;
    clearance = cl;
    weather = w;
    @(posedge clk);
    modelStep(i, o, c, cl, w);
    #1;
    checkOutput();
  endtask

  // Reset lands mid-cycle so its effect must be asynchronous.
  task automatic doReset(input string tag);
    #2;
    rst_n = 1'b0;
    pax_in = 1'b0;
    pax_out = 1'b0;
    close_req = 1'b0;
    clearance = 1'b0;
    weather = 1'b0;
    #1;
    check1({tag, "_state"}, state, 8'd0);
    check1({tag, "_passengers"}, passengers, 8'd0);
    check1({tag, "_depart_req"}, depart_req, 8'd0);
    check1({tag, "_departed"}, departed, 8'd0);
    check1({tag, "_reject"}, reject, 8'd0);
    check1({tag, "_full"}, full, 8'd0);
    modelReset();
    @(posedge clk);
    #1;
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput();
  endtask

  initial begin
    // Reset, then 15 boardings and a close request reach WAIT_CLR.
    doReset("por");
    repeat (15) applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    check1("close15_passengers", passengers, 8'd15);
    check1("close15_depart_req", depart_req, 8'd1);
    check1("close15_state", state, 8'd2);

    // Timeout with weather low: still waiting after 254 cycles, back to boarding at 255.
    repeat (CLR_TIMEOUT - 1) applyStimulus(0, 0, 0, 1, 0);
    check1("timeout_edge_state", state, 8'd2);
    applyStimulus(0, 0, 0, 1, 0);
    check1("timeout_state", state, 8'd1);
    check1("timeout_reject", reject, 8'd1);
    check1("timeout_passengers", passengers, 8'd15);

    // Clearance and weather together: eight DEPART cycles, departed on the last.
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 1);
    check1("dep1_state", state, 8'd3);
    check1("dep1_depart_req", depart_req, 8'd0);
    repeat (DEPART_CYC - 2) applyStimulus(1, 1, 1, 1, 1);
    check1("dep7_departed", departed, 8'd0);
    applyStimulus(0, 0, 0, 0, 0);
    check1("dep8_departed", departed, 8'd1);
    check1("dep8_state", state, 8'd3);
    applyStimulus(0, 0, 0, 0, 0);
    check1("postdep_state", state, 8'd0);
    check1("postdep_passengers", passengers, 8'd0);

    // Too few passengers to close.
    repeat (14) applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    check1("close14_reject", reject, 8'd1);
    check1("close14_state", state, 8'd1);
    check1("close14_passengers", passengers, 8'd14);
    repeat (14) applyStimulus(0, 1, 0, 0, 0);
    check1("empty_state", state, 8'd0);

    // Capacity limit and simultaneous in/out.
    doReset("cap");
    repeat (CAPACITY) applyStimulus(1, 0, 0, 0, 0);
    check1("cap_full", full, 8'd1);
    check1("cap_reject_before", reject, 8'd0);
    applyStimulus(1, 0, 0, 0, 0);
    check1("cap63_passengers", passengers, 8'd62);
    check1("cap63_full", full, 8'd1);
    check1("cap63_reject", reject, 8'd1);
    applyStimulus(1, 1, 0, 0, 0);
    check1("inout_passengers", passengers, 8'd62);
    check1("inout_reject", reject, 8'd0);

    // Reset during the fourth DEPART cycle.
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 1);
    repeat (3) applyStimulus(0, 0, 0, 0, 0);
    check1("dep4_state", state, 8'd3);
    doReset("middep");

    // Randomized traffic; weather alternates between mostly bad and often good.
    for (int n = 0; n < 4000; n++) begin
      bit i, o, c, cl, w;
      i  = ($urandom_range(0, 99) < 45);
      o  = ($urandom_range(0, 99) < 18);
      c  = ($urandom_range(0, 99) < 8);
      cl = ($urandom_range(0, 3) != 0);
      if (((n / 600) % 2) == 0) w = ($urandom_range(0, 399) == 0);
      else w = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 999) == 0) doReset("rnd");
      else applyStimulus(i, o, c, cl, w);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
